nivel_comida_ctrl: RTL

Food-level generator for the virtual-pet core. It drives the 2-bit `Nivel_Comida` bus that the pet-state FSM consumes, and reads back that FSM's `Visualizacion` and `Activo_Comida` outputs. While the pet is not eating, the level decays on a programmable timer. While the pet is eating, the level refills on a second timer. Both directions saturate. A one-cycle change strobe is provided for the display and sound logic.

---
 rtl/mascota_pkg.sv | 24 ++
 rtl/nivel_comida_ctrl_contador_tick.sv | 38 +++
 rtl/nivel_comida_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/mascota_pkg.sv
// Shared constants and types for the virtual-pet core.
// Visualizacion state codes, food-level bounds and food-level mode encoding.
package mascota_pkg;

    localparam int unsigned VIS_W   = 2;
    localparam int unsigned NIVEL_W = 2;

    // Visualizacion codes driven by the pet-state FSM
    localparam logic [VIS_W-1:0] VIS_IDLE       = 2'b00;
    localparam logic [VIS_W-1:0] VIS_HAMBRE     = 2'b01;
    localparam logic [VIS_W-1:0] VIS_DESNUTRIDO = 2'b10;
    localparam logic [VIS_W-1:0] VIS_COMIENDO   = 2'b11;

    // Food-level bounds
    localparam logic [NIVEL_W-1:0] NIVEL_MIN = 2'd0;
    localparam logic [NIVEL_W-1:0] NIVEL_MAX = 2'd3;

    // Food-level generator mode
    typedef enum logic {
        MODO_DECAY = 1'b0,
        MODO_FEED  = 1'b1
    } modo_t;

endpackage : mascota_pkg

// File: rtl/nivel_comida_ctrl_contador_tick.sv
// contador_tick: loadable up-counter with terminal-count compare.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - synchronous clear to zero (wins over load and count)
//   load        - load load_val into the counter
//   load_val    - value loaded when load is high
//   terminal    - terminal value; the counter wraps to 0 after reaching it
//   cnt         - current count (registered)
//   tc_c        - combinational flag, cnt == terminal
module contador_tick #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    assign tc_c = (cnt == terminal);

    // Count up, wrapping to zero on terminal count
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tc_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule : contador_tick

// File: rtl/nivel_comida_ctrl.sv
// nivel_comida_ctrl: food-level generator for the virtual-pet core.
// The level decays on a TICKS_DECAY timer while the pet is not eating and
// refills on a TICKS_FEED timer while it is; both directions saturate.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   Visualizacion  - pet FSM state code (VIS_COMIENDO = eating)
//   Activo_Comida  - pet FSM food channel enable
//   Nivel_Comida   - current food level, 0..NIVEL_MAX (registered)
//   Pulso_Cambio   - one-cycle strobe when Nivel_Comida changes (registered)
//   Modo_Llenado   - 1 while in FEED mode (registered)
//   Lleno          - 1 when Nivel_Comida == NIVEL_MAX (registered)
module nivel_comida_ctrl #(
    parameter int unsigned TICKS_DECAY = 50_000_000,
    parameter int unsigned TICKS_FEED  = 12_500_000,
    parameter logic [1:0]  NIVEL_MAX   = mascota_pkg::NIVEL_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Visualizacion,
    input  logic       Activo_Comida,
    output logic [1:0] Nivel_Comida,
    output logic       Pulso_Cambio,
    output logic       Modo_Llenado,
    output logic       Lleno
);

    import mascota_pkg::VIS_COMIENDO;
    import mascota_pkg::NIVEL_MIN;
    import mascota_pkg::NIVEL_W;
    import mascota_pkg::modo_t;
    import mascota_pkg::MODO_DECAY;
    import mascota_pkg::MODO_FEED;

    localparam int unsigned TICKS_MAX = (TICKS_DECAY > TICKS_FEED) ? TICKS_DECAY : TICKS_FEED;
    localparam int unsigned CNT_W     = $clog2(TICKS_MAX);

    localparam logic [CNT_W-1:0] TC_DECAY = CNT_W'(TICKS_DECAY - 1);
    localparam logic [CNT_W-1:0] TC_FEED  = CNT_W'(TICKS_FEED - 1);

    modo_t              modo_q;
    logic               feed_req_c;
    logic               modo_cambio_c;
    logic               paso_c;
    logic               tc_c;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   terminal_c;
    logic [NIVEL_W-1:0] nivel_nxt_c;

    assign feed_req_c    = (Visualizacion == VIS_COMIENDO) && Activo_Comida;
    assign modo_cambio_c = feed_req_c != (modo_q == MODO_FEED);
    // A mode switch takes priority over a step on the same cycle
    assign paso_c        = tc_c && !modo_cambio_c;
    assign terminal_c    = (modo_q == MODO_FEED) ? TC_FEED : TC_DECAY;

    // Single tick counter shared by both modes, cleared on mode switch
    contador_tick #(
        .W (CNT_W)
    ) u_contador_tick (
        .clk      (clk),
        .reset    (reset),
        .clear    (modo_cambio_c),
        .load     (1'b0),
        .load_val ('0),
        .terminal (terminal_c),
        .cnt      (cnt),
        .tc_c     (tc_c)
    );

    // Saturating next level
    always_comb begin
        nivel_nxt_c = Nivel_Comida;
        if (paso_c) begin
            if (modo_q == MODO_DECAY) begin
                if (Nivel_Comida != NIVEL_MIN) begin
                    nivel_nxt_c = Nivel_Comida - NIVEL_W'(1);
                end
            end else begin
                if (Nivel_Comida != NIVEL_MAX) begin
                    nivel_nxt_c = Nivel_Comida + NIVEL_W'(1);
                end
            end
        end
    end

    // Mode FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            modo_q       <= MODO_DECAY;
            Nivel_Comida <= NIVEL_MAX;
            Pulso_Cambio <= 1'b0;
            Modo_Llenado <= 1'b0;
            Lleno        <= 1'b1;
        end else begin
            case (modo_q)
                MODO_DECAY: if (feed_req_c)  modo_q <= MODO_FEED;
                MODO_FEED:  if (!feed_req_c) modo_q <= MODO_DECAY;
                default:    modo_q <= MODO_DECAY;
            endcase
            Modo_Llenado <= feed_req_c;
            Nivel_Comida <= nivel_nxt_c;
            Pulso_Cambio <= (nivel_nxt_c != Nivel_Comida);
            Lleno        <= (nivel_nxt_c == NIVEL_MAX);
        end
    end

endmodule : nivel_comida_ctrl
